// File: rtl/fetch_buffer.sv
// Instruction queue between fetch and decode: a circular FIFO of {pc, instr}
// pairs whose registered occupancy drives the fetch-stage PC enable.
module fetch_buffer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [31:0]      in_pc,
  input  logic [31:0]      in_instr,
  output logic             in_ready,
  output logic             out_valid,
  output logic [31:0]      out_pc,
  output logic [31:0]      out_instr,
  input  logic             out_ready,
  input  logic             flush,
  output logic [CNT_W-1:0] count
);

  localparam int          PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] NOP   = 32'h0000_0013;  // ADDI x0,x0,0

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic             push;
  logic             pop;
  entry_t           head;

  // Handshakes look only at registered occupancy, so a full buffer refuses a
  // push even when decode pops in the same cycle; this keeps out_ready off
  // the PC-enable path.
  assign in_ready  = (count_q != CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid  & in_ready  & ~flush;
  assign pop       = out_valid & out_ready & ~flush;
  assign count     = count_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: the storage array is deliberately left out of reset; occupancy and
  // pointers already define which entries are live, and unreset memory maps
  // cleanly onto RAM or plain flops without a reset tree.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{pc: in_pc, instr: in_instr};
  end

  assign head = mem[rd_ptr];

  // NOTE: every output of this block gets a default before the conditional,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    out_pc    = '0;
    out_instr = NOP;
    if (out_valid) begin
      out_pc    = head.pc;
      out_instr = head.instr;
    end
  end

endmodule

// File: doc/fetch_buffer.md
# fetch_buffer

Instruction queue between the fetch stage (PC register + instruction memory) and the decode stage. Captures each fetched {pc, instruction} pair into a small circular FIFO so that decode back-pressure does not stall the PC register combinationally. Provides `in_ready` to gate the fetch-stage PC enable. A branch/jump `flush` discards all buffered and in-flight entries.

## Interface
Parameters:
- `DEPTH`, default 4: number of entries; power of two, ≥ 2.
- `CNT_W`, default 3: occupancy width, equal to $clog2(DEPTH+1).

Ports (one clock; reset is synchronous and active-high):
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  synchronous active-high reset.
- `in_valid`  input  1  fetch stage presents a valid pair this cycle.
- `in_pc`  input  32  PC of the fetched instruction.
- `in_instr`  input  32  instruction word from instruction memory.
- `in_ready`  output  1  buffer can accept; fetch uses it as PC enable.
- `out_valid`  output  1  head entry valid for decode.
- `out_pc`  output  32  PC of head entry.
- `out_instr`  output  32  instruction of head entry.
- `out_ready`  input  1  decode consumes head this cycle.
- `flush`  input  1  redirect from execute; empty the buffer.
- `count`  output  CNT_W  current occupancy, 0..DEPTH.

## Operation
- Storage: DEPTH × 64-bit array of {pc, instr}; write pointer `wr_ptr` and read pointer `rd_ptr`, each log2(DEPTH) bits, wrapping modulo DEPTH; separate `count` register distinguishes full from empty.
- `in_ready = (count != DEPTH)`. Combinational from registered count only; no pass-through of `out_ready` (a full buffer never accepts, even if popping the same cycle).
- `out_valid = (count != 0)`. `out_pc`/`out_instr` = entry at `rd_ptr` when valid; when empty, `out_pc = 0`, `out_instr = 32'h00000013` (ADDI x0,x0,0 NOP).
- push = `in_valid & in_ready & ~flush`: write entry at `wr_ptr`, increment `wr_ptr`.
- pop = `out_valid & out_ready & ~flush`: increment `rd_ptr`.
- count update: push&~pop → +1; pop&~push → −1; both or neither → unchanged.
- `flush` (priority below `rst`, above push/pop): `wr_ptr`, `rd_ptr`, `count` ← 0; the `in_*` pair presented in the flush cycle is dropped; no pop is counted. Array contents need not be cleared.
- `rst`: same clearing as flush; highest priority.
- Priority per cycle: rst > flush > push/pop.
- Pushing while `in_ready = 0` is ignored (no overwrite); popping while empty is ignored (no underflow). Count never leaves 0..DEPTH.

## Timing
- Reset values: `count = 0`, `in_ready = 1`, `out_valid = 0`, `out_pc = 0`, `out_instr = 32'h00000013`.
- Latency: pair pushed at edge N is visible on `out_*` with `out_valid = 1` after edge N (cycle N+1); no same-cycle bypass.
- Throughput: one push and one pop per cycle when 0 < count < DEPTH.
- `in_ready` deasserts the cycle after the push that makes count = DEPTH; reasserts the cycle after the first pop from full.
- Flush in cycle N: from cycle N+1 `out_valid = 0`, `in_ready = 1`, `count = 0`; a push in N+1 appears at output in N+2.
- Wrap-around: after writing entry DEPTH−1, `wr_ptr` returns to 0; FIFO order is preserved across the wrap.

## Test plan
- Reset: hold `rst` 2 cycles with `in_valid = 1` → `count = 0`, `out_valid = 0`, `out_instr = 0x00000013`, `in_ready = 1`; no entry captured.
- Fill/full: push PCs 0x0,0x4,0x8,0xC with `out_ready = 0` → `count = 4`, `in_ready = 0`; a 5th push of 0x10 is ignored; then drain with `out_ready = 1` → out PCs 0x0,0x4,0x8,0xC in order, then `out_valid = 0`.
- Streaming: continuous push of 0x0..0x3C with `out_ready = 1` → `count` stays 1 after the first cycle, every instruction delivered in order, one per cycle.
- Wrap-around: push 3, pop 3, push 4, pop 4 → all 7 entries in order; pointers wrapped; `count` returns to 0.
- Flush: with count = 3, assert `flush` together with `in_valid` (pc 0x40) and `out_ready` → next cycle `count = 0`, `out_valid = 0`; 0x40 never emitted; push of 0x80 the following cycle is output one cycle later.
- Reset mid-operation: `rst` with count = 2 while pushing and popping → next cycle all outputs at reset values; subsequent pushes start at entry 0.
